// File: rtl/apb_mem_slave.sv
// APB slave backed by a DEPTH x DATA_W word memory with byte-lane strobes,
// programmable wait states and address-error reporting through PSLVERR.
module apb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic                PREADY,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PSLVERR
);

  // state  | meaning
  // IDLE   | no transfer in flight; waiting for a setup phase
  // ACCESS | setup captured; counting wait states, completes when wcnt hits 0

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] LSB_MASK  = ADDR_W'((1 << LSB) - 1);
  localparam logic [ADDR_W:0]   DEPTH_CMP = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]        WAIT_LD   = 4'(WAIT_CYCLES);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t              state;
  logic [3:0]          wcnt;
  logic [DATA_W-1:0]   rd_q;
  logic                err_q;
  logic [IDX_W-1:0]    idx_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   word_idx;
  logic                misaligned;
  logic                addr_err;
  logic                setup;
  logic                wr_en;

  assign word_idx   = PADDR >> LSB;
  assign misaligned = |(PADDR & LSB_MASK);
  assign addr_err   = ({1'b0, word_idx} >= DEPTH_CMP) || misaligned;
  assign setup      = PSEL && !PENABLE;

  assign PREADY  = (state == ACCESS) && (wcnt == 4'd0) && PSEL && PENABLE;
  assign PSLVERR = PREADY && err_q;
  assign PRDATA  = (PREADY && !PWRITE && !err_q) ? rd_q : '0;
  assign wr_en   = PREADY && PWRITE && !err_q;

  // A setup phase seen while already in ACCESS restarts the transfer so a
  // confused master cannot leave the slave stuck on stale address state.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      wcnt  <= 4'd0;
      rd_q  <= '0;
      err_q <= 1'b0;
      idx_q <= '0;
    end else if (setup) begin
      state <= ACCESS;
      wcnt  <= WAIT_LD;
      err_q <= addr_err;
      idx_q <= word_idx[IDX_W-1:0];
      rd_q  <= addr_err ? '0 : mem[word_idx[IDX_W-1:0]];
    end else if (state == ACCESS) begin
      if (!PSEL) begin
        state <= IDLE;
        wcnt  <= 4'd0;
      end else if (wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end else begin
        state <= IDLE;
      end
    end
  end

  // Memory is deliberately left out of reset; wr_en is gated by state, which
  // reset clears asynchronously, so an interrupted write never lands.
  always_ff @(posedge PCLK) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (PSTRB[i]) mem[idx_q][8*i +: 8] <= PWDATA[8*i +: 8];
      end
    end
  end

endmodule
